// File: rtl/console_pkg.sv
// console_pkg
// Shared definitions for the UART text console controller: the control codes
// the console interprets, the sequencer state type and a character-class helper.
// No ports (package).

package console_pkg;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WRITE,
        ST_CLEAR_ROW,
        ST_CLEAR_ALL
    } console_state_t;

    // Printable ASCII range that is written straight to the framebuffer.
    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= 8'h20) && (ch <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_text_console_ctrl_if.sv
// uart_text_console_ctrl_if
// Bundles the byte-receive strobe and the framebuffer write request/grant port
// of the text console controller.
//   rx_data/rx_valid : received byte and its 1-cycle strobe (into the console)
//   wr_req/wr_grant  : framebuffer write request and its acceptance
//   wr_addr/wr_char  : framebuffer cell address (row*COLS+col) and character
// modport master : the console controller
// modport slave  : the UART receiver / framebuffer arbiter side

interface uart_text_console_ctrl_if #(
    parameter int COLS = 16,
    parameter int ROWS = 4
);
    localparam int ADDR_W = $clog2(ROWS * COLS);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_req;
    logic              wr_grant;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_char;

    modport master (
        input  rx_data, rx_valid, wr_grant,
        output wr_req, wr_addr, wr_char
    );

    modport slave (
        output rx_data, rx_valid, wr_grant,
        input  wr_req, wr_addr, wr_char
    );

endinterface

// File: rtl/console_byte_fifo.sv
// console_byte_fifo
// Small synchronous byte FIFO between the UART receiver and the console sequencer.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push/din : write din when push (ignored when full unless popping the same cycle)
//   pop/dout : dout shows the oldest entry; pop removes it (ignored when empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two.

module console_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [7:0]     mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_text_console_ctrl.sv
// uart_text_console_ctrl
// Turns a stream of received UART bytes into character writes for an OLED text
// framebuffer. Printable bytes are written at the cursor; BS, CR, LF and FF move
// the cursor and, for LF/FF (and wrapping past the last column), blank the new
// row or the whole screen. Writes go out over a req/grant port shared with the
// display refresh engine.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : rx_data/rx_valid in, wr_req/wr_addr/wr_char out, wr_grant in
//   cursor_row/col: current text cursor
//   fifo_ovf      : 1-cycle pulse when a received byte was dropped (FIFO full)
//   busy          : sequencer active or bytes still queued

module uart_text_console_ctrl
    import console_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_text_console_ctrl_if.master  bus,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      fifo_ovf,
    output logic                      busy
);
    localparam int ADDR_W = $clog2(ROWS * COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);

    localparam logic [ROW_W-1:0]  LAST_ROW      = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_CELL = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(ROWS * COLS - 1);

    console_state_t    state;
    logic [7:0]        cur_byte;
    logic              advance;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ROW_W-1:0]  next_row;

    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    console_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.rx_valid),
        .pop   (fifo_pop),
        .din   (bus.rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    // No scrolling: the row after the last one is row 0, which gets blanked.
    assign next_row = (cursor_row == LAST_ROW) ? '0 : cursor_row + 1'b1;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    // A byte is lost only if the FIFO is full and the sequencer is not draining it this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_ovf <= 1'b0;
        end else begin
            fifo_ovf <= bus.rx_valid && fifo_full && !fifo_pop;
        end
    end

    // Sequencer: fetch a byte, decode it, then hold a write request (single write
    // or a run of blanking writes) until every write has been granted.
    // 'advance' remembers whether the pending single write moves the cursor on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_byte    <= '0;
            advance     <= 1'b0;
            clr_cnt     <= '0;
            cursor_row  <= '0;
            cursor_col  <= '0;
            bus.wr_req  <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_char <= CH_SP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_byte <= fifo_dout;
                        state    <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (is_printable(cur_byte)) begin
                        bus.wr_req  <= 1'b1;
                        bus.wr_addr <= cell_addr(cursor_row, cursor_col);
                        bus.wr_char <= cur_byte;
                        advance     <= 1'b1;
                        state       <= ST_WRITE;
                    end else begin
                        case (cur_byte)
                            CH_BS: begin
                                if (cursor_col != '0) begin
                                    cursor_col  <= cursor_col - 1'b1;
                                    bus.wr_req  <= 1'b1;
                                    bus.wr_addr <= cell_addr(cursor_row, cursor_col - 1'b1);
                                    bus.wr_char <= CH_SP;
                                    advance     <= 1'b0;
                                    state       <= ST_WRITE;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                            CH_CR: begin
                                cursor_col <= '0;
                                state      <= ST_IDLE;
                            end
                            CH_LF: begin
                                cursor_col  <= '0;
                                cursor_row  <= next_row;
                                bus.wr_req  <= 1'b1;
                                bus.wr_addr <= cell_addr(next_row, COL_W'(0));
                                bus.wr_char <= CH_SP;
                                clr_cnt     <= '0;
                                state       <= ST_CLEAR_ROW;
                            end
                            CH_FF: begin
                                cursor_col  <= '0;
                                cursor_row  <= '0;
                                bus.wr_req  <= 1'b1;
                                bus.wr_addr <= '0;
                                bus.wr_char <= CH_SP;
                                clr_cnt     <= '0;
                                state       <= ST_CLEAR_ALL;
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end

                ST_WRITE: begin
                    if (bus.wr_grant) begin
                        if (advance && (cursor_col == LAST_COL)) begin
                            // Line wrap: request stays up and flows into blanking the new row.
                            cursor_col  <= '0;
                            cursor_row  <= next_row;
                            bus.wr_addr <= cell_addr(next_row, COL_W'(0));
                            bus.wr_char <= CH_SP;
                            clr_cnt     <= '0;
                            state       <= ST_CLEAR_ROW;
                        end else begin
                            if (advance) begin
                                cursor_col <= cursor_col + 1'b1;
                            end
                            bus.wr_req <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end

                ST_CLEAR_ROW, ST_CLEAR_ALL: begin
                    if (bus.wr_grant) begin
                        if (clr_cnt == ((state == ST_CLEAR_ROW) ? LAST_ROW_CELL : LAST_CELL)) begin
                            bus.wr_req <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            clr_cnt     <= clr_cnt + 1'b1;
                            bus.wr_addr <= bus.wr_addr + 1'b1;
                        end
                    end
                end

                default: begin
                    bus.wr_req <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_text_console_ctrl.sv
// tb_uart_text_console_ctrl
// Self-checking bench for uart_text_console_ctrl. A behavioural console model
// (cursor position plus a queue of expected framebuffer writes) is updated for
// every byte sent; a monitor records every granted write, request edges and
// overflow pulses, and each test task compares them with the model.

module tb_uart_text_console_ctrl;
    import console_pkg::*;

    localparam int COLS       = 16;
    localparam int ROWS       = 4;
    localparam int FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       fifo_ovf;
    logic       busy;

    uart_text_console_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    uart_text_console_ctrl #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .fifo_ovf   (fifo_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int          mrow = 0;
    int          mcol = 0;
    logic [13:0] exp_q[$];

    // Monitor state
    logic [13:0] obs_q[$];
    int          obs_cyc[$];
    int          cyc       = 0;
    int          req_cnt   = 0;
    int          ovf_cnt   = 0;
    int          ovf_cyc   = -1;
    int          rise_cyc  = -1;
    int          hold_viol = 0;
    int          push_cyc  = 0;
    int          grant_mode = 0;   // 0 = low, 1 = high, 2 = random

    // ---------------- monitor ----------------
    initial begin
        logic        prev_req;
        logic        stalled;
        logic [13:0] stall_word;
        prev_req = 1'b0;
        stalled  = 1'b0;
        stall_word = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_req = 1'b0;
                stalled  = 1'b0;
            end else begin
                if (stalled && (!bus.wr_req || {bus.wr_addr, bus.wr_char} != stall_word)) begin
                    hold_viol++;
                end
                if (bus.wr_req && bus.wr_grant) begin
                    obs_q.push_back({bus.wr_addr, bus.wr_char});
                    obs_cyc.push_back(cyc);
                end
                if (bus.wr_req) req_cnt++;
                if (bus.wr_req && !prev_req) rise_cyc = cyc;
                prev_req   = bus.wr_req;
                stalled    = bus.wr_req && !bus.wr_grant;
                stall_word = {bus.wr_addr, bus.wr_char};
                if (fifo_ovf) begin
                    ovf_cnt++;
                    ovf_cyc = cyc;
                end
            end
        end
    end

    // ---------------- grant driver ----------------
    initial begin
        bus.wr_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (grant_mode)
                0:       bus.wr_grant = 1'b0;
                1:       bus.wr_grant = 1'b1;
                default: bus.wr_grant = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- behavioural model ----------------
    function automatic void exp_write(input int addr, input int ch);
        exp_q.push_back({6'(addr), 8'(ch)});
    endfunction

    function automatic void model_blank_row(input int r);
        for (int c = 0; c < COLS; c++) exp_write(r * COLS + c, 'h20);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_write(mrow * COLS + mcol, int'(b));
            if (mcol == COLS - 1) begin
                mcol = 0;
                mrow = (mrow + 1) % ROWS;
                model_blank_row(mrow);
            end else begin
                mcol++;
            end
        end else if (b == CH_BS) begin
            if (mcol > 0) begin
                mcol--;
                exp_write(mrow * COLS + mcol, 'h20);
            end
        end else if (b == CH_CR) begin
            mcol = 0;
        end else if (b == CH_LF) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
            model_blank_row(mrow);
        end else if (b == CH_FF) begin
            mrow = 0;
            mcol = 0;
            for (int a = 0; a < ROWS * COLS; a++) exp_write(a, 'h20);
        end
    endfunction

    function automatic int write_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic string diff_text(input int d);
        return $sformatf("write #%0d: got %0d writes (addr/char %h), want %0d writes (addr/char %h)",
                         d, obs_q.size(), (d < obs_q.size()) ? obs_q[d] : 14'h0,
                         exp_q.size(), (d < exp_q.size()) ? exp_q[d] : 14'h0);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic push_byte(input logic [7:0] b, input bit modeled);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        push_cyc     = cyc + 1;
        if (modeled) model_byte(b);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int  k;
        bit  done;
        done = 1'b0;
        for (k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            n_checks++;
            $display("[TB] FAIL %s idle-timeout: busy=%b after %0d cycles, want 0", name, busy, k);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        mrow = 0; mcol = 0;
        req_cnt = 0; ovf_cnt = 0; ovf_cyc = -1; rise_cyc = -1; hold_viol = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        @(posedge clk);
        #1;
        n_checks++; if (bus.wr_req !== 1'b0)     $display("[TB] FAIL reset wr_req: got %b want 0", bus.wr_req);     else n_pass++;
        n_checks++; if (bus.wr_addr !== 6'd0)    $display("[TB] FAIL reset wr_addr: got %0d want 0", bus.wr_addr); else n_pass++;
        n_checks++; if (bus.wr_char !== 8'h20)   $display("[TB] FAIL reset wr_char: got %h want 20", bus.wr_char); else n_pass++;
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0)
                        $display("[TB] FAIL reset cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);   else n_pass++;
        n_checks++; if (fifo_ovf !== 1'b0)       $display("[TB] FAIL reset fifo_ovf: got %b want 0", fifo_ovf);    else n_pass++;
        n_checks++; if (busy !== 1'b0)           $display("[TB] FAIL reset busy: got %b want 0", busy);            else n_pass++;
        do_reset();
    endtask

    task automatic test_single_char();
        int d;
        do_reset();
        grant_mode = 1;
        @(posedge clk); #1;
        push_byte(8'h41, 1'b1);
        wait_idle("single_char");
        n_checks++; if (rise_cyc != push_cyc + 3)
                        $display("[TB] FAIL single_char latency: wr_req rose %0d cycles after rx_valid, want 3", rise_cyc - push_cyc);
                    else n_pass++;
        d = write_diff();
        n_checks++; if (d >= 0) $display("[TB] FAIL single_char writes: %s", diff_text(d)); else n_pass++;
        n_checks++; if (cursor_row !== 2'(mrow) || cursor_col !== 4'(mcol))
                        $display("[TB] FAIL single_char cursor: got (%0d,%0d) want (%0d,%0d)", cursor_row, cursor_col, mrow, mcol);
                    else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL single_char busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_row_wrap();
        int d;
        do_reset();
        grant_mode = 1;
        for (int i = 0; i < COLS; i++) begin
            push_byte(8'h61, 1'b1);
            wait_idle("row_wrap");
        end
        d = write_diff();
        n_checks++; if (d >= 0) $display("[TB] FAIL row_wrap writes: %s", diff_text(d)); else n_pass++;
        n_checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd0)
                        $display("[TB] FAIL row_wrap cursor: got (%0d,%0d) want (1,0)", cursor_row, cursor_col);
                    else n_pass++;
    endtask

    task automatic test_backspace();
        int d;
        int r0;
        do_reset();
        grant_mode = 1;
        for (int i = 0; i < 3; i++) begin
            push_byte(8'($urandom_range(32, 126)), 1'b1);
            wait_idle("backspace");
        end
        push_byte(CH_BS, 1'b1);
        wait_idle("backspace");
        n_checks++; if (obs_q.size() != 4 || obs_q[obs_q.size()-1] !== {6'd2, 8'h20})
                        $display("[TB] FAIL backspace write: got %0d writes last %h, want 4 writes last %h",
                                 obs_q.size(), obs_q[obs_q.size()-1], {6'd2, 8'h20});
                    else n_pass++;
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd2)
                        $display("[TB] FAIL backspace cursor: got (%0d,%0d) want (0,2)", cursor_row, cursor_col);
                    else n_pass++;
        repeat (2) begin
            push_byte(CH_BS, 1'b1);
            wait_idle("backspace");
        end
        r0 = req_cnt;
        push_byte(CH_BS, 1'b1);
        wait_idle("backspace_col0");
        n_checks++; if (req_cnt != r0)
                        $display("[TB] FAIL backspace_col0 wr_req: got %0d request cycles, want 0", req_cnt - r0);
                    else n_pass++;
        d = write_diff();
        n_checks++; if (d >= 0) $display("[TB] FAIL backspace writes: %s", diff_text(d)); else n_pass++;
        n_checks++; if (cursor_row !== 2'(mrow) || cursor_col !== 4'(mcol))
                        $display("[TB] FAIL backspace_col0 cursor: got (%0d,%0d) want (%0d,%0d)", cursor_row, cursor_col, mrow, mcol);
                    else n_pass++;
    endtask

    task automatic test_form_feed();
        int d;
        int base;
        int gaps;
        do_reset();
        grant_mode = 1;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'($urandom_range(32, 126)), 1'b1);
            wait_idle("form_feed");
        end
        base = obs_q.size();
        push_byte(CH_FF, 1'b1);
        wait_idle("form_feed");
        d = write_diff();
        n_checks++; if (d >= 0) $display("[TB] FAIL form_feed writes: %s", diff_text(d)); else n_pass++;
        n_checks++; if (obs_q.size() - base != ROWS * COLS)
                        $display("[TB] FAIL form_feed count: got %0d clears want %0d", obs_q.size() - base, ROWS * COLS);
                    else n_pass++;
        gaps = 0;
        for (int i = base + 1; i < obs_cyc.size(); i++) if (obs_cyc[i] - obs_cyc[i-1] != 1) gaps++;
        n_checks++; if (gaps != 0) $display("[TB] FAIL form_feed back_to_back: got %0d gaps want 0", gaps); else n_pass++;
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0)
                        $display("[TB] FAIL form_feed cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
                    else n_pass++;
    endtask

    task automatic test_overflow();
        int d;
        int p10;
        do_reset();
        grant_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        p10 = 0;
        for (int i = 0; i < 10; i++) begin
            push_byte(8'($urandom_range(32, 126)), (i < 9));
            if (i == 9) p10 = push_cyc;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ovf_cnt != 1) $display("[TB] FAIL overflow count: got %0d pulses want 1", ovf_cnt); else n_pass++;
        n_checks++; if (ovf_cyc != p10 + 1)
                        $display("[TB] FAIL overflow timing: pulse at cycle %0d want %0d", ovf_cyc, p10 + 1);
                    else n_pass++;
        n_checks++; if (obs_q.size() != 0 || bus.wr_req !== 1'b1)
                        $display("[TB] FAIL overflow stall: got %0d writes wr_req=%b want 0 writes wr_req=1", obs_q.size(), bus.wr_req);
                    else n_pass++;
        grant_mode = 1;
        wait_idle("overflow");
        d = write_diff();
        n_checks++; if (d >= 0) $display("[TB] FAIL overflow writes: %s", diff_text(d)); else n_pass++;
        n_checks++; if (hold_viol != 0) $display("[TB] FAIL overflow hold: got %0d unstable stalls want 0", hold_viol); else n_pass++;
        n_checks++; if (cursor_row !== 2'(mrow) || cursor_col !== 4'(mcol))
                        $display("[TB] FAIL overflow cursor: got (%0d,%0d) want (%0d,%0d)", cursor_row, cursor_col, mrow, mcol);
                    else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int base;
        int n_obs;
        int r0;
        int bad;
        int k;
        do_reset();
        grant_mode = 1;
        repeat (3) begin
            push_byte(CH_LF, 1'b1);
            wait_idle("reset_mid_clear");
        end
        for (int i = 0; i < COLS - 1; i++) begin
            push_byte(8'($urandom_range(32, 126)), 1'b1);
            wait_idle("reset_mid_clear");
        end
        n_checks++; if (cursor_row !== 2'd3 || cursor_col !== 4'd15)
                        $display("[TB] FAIL reset_mid_clear start cursor: got (%0d,%0d) want (3,15)", cursor_row, cursor_col);
                    else n_pass++;
        base = obs_q.size();
        push_byte(8'h5A, 1'b1);
        for (k = 0; k < 200 && obs_q.size() < base + 6; k++) begin
            @(posedge clk);
            #1;
        end
        n_checks++; if (obs_q.size() < base + 6 || obs_q[base] !== {6'd63, 8'h5A} || obs_q[base+1] !== {6'd0, 8'h20})
                        $display("[TB] FAIL reset_mid_clear wrap: got %0d writes first %h want >=6 first %h",
                                 obs_q.size() - base, obs_q[base], {6'd63, 8'h5A});
                    else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.wr_req !== 1'b0)
                        $display("[TB] FAIL reset_mid_clear wr_req: got %b want 0", bus.wr_req);
                    else n_pass++;
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0)
                        $display("[TB] FAIL reset_mid_clear cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
                    else n_pass++;
        n_obs = obs_q.size();
        bad = 0;
        for (int i = 0; i < n_obs; i++) if (i >= exp_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_checks++; if (bad != 0) $display("[TB] FAIL reset_mid_clear prefix: got %0d wrong writes want 0", bad); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        r0 = req_cnt;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (obs_q.size() != n_obs || req_cnt != r0)
                        $display("[TB] FAIL reset_mid_clear abandon: got %0d extra writes %0d request cycles want 0",
                                 obs_q.size() - n_obs, req_cnt - r0);
                    else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [7:0] ctrl_tab [8];
        logic [7:0] b;
        int d;
        ctrl_tab = '{8'h08, 8'h0A, 8'h0D, 8'h0C, 8'h00, 8'h1B, 8'h7F, 8'hFF};
        do_reset();
        grant_mode = 2;
        for (int g = 0; g < 10; g++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 99) < 70) b = 8'($urandom_range(32, 126));
                else                            b = ctrl_tab[$urandom_range(0, 7)];
                push_byte(b, 1'b1);
            end
            wait_idle("random_stream");
        end
        grant_mode = 1;
        d = write_diff();
        n_checks++; if (d >= 0) $display("[TB] FAIL random_stream writes: %s", diff_text(d)); else n_pass++;
        n_checks++; if (cursor_row !== 2'(mrow) || cursor_col !== 4'(mcol))
                        $display("[TB] FAIL random_stream cursor: got (%0d,%0d) want (%0d,%0d)", cursor_row, cursor_col, mrow, mcol);
                    else n_pass++;
        n_checks++; if (hold_viol != 0) $display("[TB] FAIL random_stream hold: got %0d unstable stalls want 0", hold_viol); else n_pass++;
        n_checks++; if (ovf_cnt != 0) $display("[TB] FAIL random_stream overflow: got %0d pulses want 0", ovf_cnt); else n_pass++;
    endtask

    // ---------------- sequence ----------------
    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        test_reset();
        test_single_char();
        test_row_wrap();
        test_backspace();
        test_form_feed();
        test_overflow();
        test_reset_mid_clear();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
